// File: rtl/decoder_in_encoder_if.sv
// Valid/ready stream bundle for the one-hot to binary encoder: one-hot words in, encoded index plus flags out.
interface decoder_in_encoder_if #(
  parameter int N_IN = 8
);
  localparam int OUT_W = $clog2(N_IN);

  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_idx;
  logic             out_zero;
  logic             out_multi;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_zero, out_multi
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_zero, out_multi
  );
endinterface

// File: rtl/decoder_in_encoder.sv
// Stream encoder: one-hot word -> MSB-priority binary index with zero/multi-hot flags, 2-entry output buffer.
// Optional saturating error counter on err_cnt when DECODER_IN_ERR_CNT_EN is defined.
module decoder_in_encoder #(
  parameter  int N_IN  = 8,
  localparam int OUT_W = $clog2(N_IN)
) (
  input  logic                clk,
  input  logic                rst_n,
  decoder_in_encoder_if.slave stream
`ifdef DECODER_IN_ERR_CNT_EN
  ,
  output logic [15:0]         err_cnt
`endif
);

  localparam int ENTRY_W = OUT_W + 2;

  logic               released;
  logic [1:0]         count;
  logic               wr_ptr;
  logic               rd_ptr;
  logic [ENTRY_W-1:0] mem [2];

  logic               in_ready;
  logic               push;
  logic               pop;
  logic [OUT_W-1:0]   enc_idx;
  logic               enc_zero;
  logic               enc_multi;
  logic               seen;
  logic [ENTRY_W-1:0] head;

  assign in_ready = released && (count != 2'd2);
  assign push     = stream.in_valid && in_ready;
  assign pop      = stream.out_ready && (count != 2'd0);

  // Later (higher) set bits overwrite the index, giving MSB priority; a second hit marks multi-hot.
  always_comb begin
    enc_idx   = '0;
    enc_multi = 1'b0;
    seen      = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (stream.in_vec[i]) begin
        enc_idx   = OUT_W'(i);
        enc_multi = enc_multi | seen;
        seen      = 1'b1;
      end
    end
    enc_zero = ~seen;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      released <= 1'b0;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      released <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= {enc_idx, enc_zero, enc_multi};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Outputs come straight from buffer storage, so they hold while the consumer stalls.
  assign head             = mem[rd_ptr];
  assign stream.in_ready  = in_ready;
  assign stream.out_valid = (count != 2'd0);
  assign stream.out_idx   = head[ENTRY_W-1:2];
  assign stream.out_zero  = head[1];
  assign stream.out_multi = head[0];

`ifdef DECODER_IN_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 16'h0000;
    end else if (push && (enc_zero || enc_multi) && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'h0001;
    end
  end
`endif

endmodule
